// File: rtl/maze_carver_dfs.sv
// rtl/maze_carver_dfs.sv - randomized DFS perfect-maze carver; optional step/depth stats via MAZE_CARVER_DFS_STATS_EN
module maze_carver_dfs #(
    parameter int          MAZE_W  = 16,
    parameter int          MAZE_H  = 16,
    parameter int          START_X = 1,
    parameter int          START_Y = 1,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [MAZE_W*MAZE_H-1:0] maze_data
`ifdef MAZE_CARVER_DFS_STATS_EN
    ,
    output logic [15:0]              step_count,
    output logic [15:0]              max_depth
`endif
);
    localparam int N_CELLS = MAZE_W * MAZE_H;
    localparam int ROOMS   = ((MAZE_W - 1) / 2) * ((MAZE_H - 1) / 2);
    localparam int AW      = $clog2(N_CELLS);
    localparam int SPW     = $clog2(ROOMS);
    // Largest coordinate from which a +2 jump still lands inside the border.
    localparam logic [6:0] X_HI = 7'(MAZE_W - 4);
    localparam logic [6:0] Y_HI = 7'(MAZE_H - 4);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_CHECK, S_STEP, S_POP, S_DONE} state_t;

    state_t         state, state_next;
    logic           accept;
    logic [15:0]    lfsr;
    logic [SPW-1:0] sp;
    logic [6:0]     cur_x, cur_y;
    logic [1:0]     dir_q, dir_sel, probe;
    logic           found;
    logic [3:0]     cand;
    logic [6:0]     tgt_x [4];
    logic [6:0]     tgt_y [4];
    logic [6:0]     step_x, step_y;
    logic [7:0]     sum_x, sum_y;
    logic [13:0]    stack [ROOMS];
    logic [13:0]    pop_entry;

    function automatic logic [AW-1:0] cell_idx(input logic [6:0] x, input logic [6:0] y);
        int t;
        t = int'(x) + MAZE_W * int'(y);
        return AW'(t);
    endfunction

    // Neighbour targets; an out-of-bounds direction points back at cur so its index stays legal.
    always_comb begin
        tgt_x[0] = cur_x;
        tgt_y[0] = (cur_y >= 7'd3) ? cur_y - 7'd2 : cur_y;
        tgt_x[1] = (cur_x <= X_HI) ? cur_x + 7'd2 : cur_x;
        tgt_y[1] = cur_y;
        tgt_x[2] = cur_x;
        tgt_y[2] = (cur_y <= Y_HI) ? cur_y + 7'd2 : cur_y;
        tgt_x[3] = (cur_x >= 7'd3) ? cur_x - 7'd2 : cur_x;
        tgt_y[3] = cur_y;
        cand[0]  = (cur_y >= 7'd3) && !maze_data[cell_idx(tgt_x[0], tgt_y[0])];
        cand[1]  = (cur_x <= X_HI) && !maze_data[cell_idx(tgt_x[1], tgt_y[1])];
        cand[2]  = (cur_y <= Y_HI) && !maze_data[cell_idx(tgt_x[2], tgt_y[2])];
        cand[3]  = (cur_x >= 7'd3) && !maze_data[cell_idx(tgt_x[3], tgt_y[3])];
    end

    // Random direction pick: start at LFSR[1:0], rotate N->E->S->W to the first open candidate.
    always_comb begin
        dir_sel = lfsr[1:0];
        probe   = lfsr[1:0];
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            probe = lfsr[1:0] + 2'(i);
            if (!found && cand[probe]) begin
                dir_sel = probe;
                found   = 1'b1;
            end
        end
    end

    // Jump target latched in CHECK, and the wall cell halfway to it.
    always_comb begin
        step_x    = tgt_x[dir_q];
        step_y    = tgt_y[dir_q];
        sum_x     = {1'b0, cur_x} + {1'b0, step_x};
        sum_y     = {1'b0, cur_y} + {1'b0, step_y};
        pop_entry = stack[sp - SPW'(1)];
    end

    // Next-state logic; start is honoured only when no run is in flight.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: state_next = S_CHECK;
            S_CHECK: begin
                if (cand != 4'd0)   state_next = S_STEP;
                else if (sp == '0)  state_next = S_DONE;
                else                state_next = S_POP;
            end
            S_STEP:  state_next = S_CHECK;
            S_POP:   state_next = S_CHECK;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Backtrack stack holds plain data, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == S_STEP) stack[sp] <= {cur_x, cur_y};
    end

    // Datapath: free-running LFSR, maze bitmap, cursor, stack pointer and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= SEED;
            busy       <= 1'b0;
            done       <= 1'b0;
            maze_data  <= '0;
            sp         <= '0;
            cur_x      <= 7'(START_X);
            cur_y      <= 7'(START_Y);
            dir_q      <= 2'd0;
`ifdef MAZE_CARVER_DFS_STATS_EN
            step_count <= 16'd0;
            max_depth  <= 16'd0;
`endif
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        maze_data  <= '0;
                        sp         <= '0;
                        cur_x      <= 7'(START_X);
                        cur_y      <= 7'(START_Y);
                        busy       <= 1'b1;
`ifdef MAZE_CARVER_DFS_STATS_EN
                        step_count <= 16'd0;
                        max_depth  <= 16'd0;
`endif
                    end
                end
                S_CLEAR: maze_data[cell_idx(cur_x, cur_y)] <= 1'b1;
                S_CHECK: begin
                    dir_q <= dir_sel;
                    if (state_next == S_DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                S_STEP: begin
                    sp <= sp + SPW'(1);
                    maze_data[cell_idx(sum_x[7:1], sum_y[7:1])] <= 1'b1;
                    maze_data[cell_idx(step_x, step_y)]         <= 1'b1;
                    cur_x <= step_x;
                    cur_y <= step_y;
`ifdef MAZE_CARVER_DFS_STATS_EN
                    step_count <= step_count + 16'd1;
                    if (16'(sp) + 16'd1 > max_depth) max_depth <= 16'(sp) + 16'd1;
`endif
                end
                S_POP: begin
                    sp    <= sp - SPW'(1);
                    cur_x <= pop_entry[13:7];
                    cur_y <= pop_entry[6:0];
                end
                default: ;
            endcase
        end
    end
endmodule
